// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC and fetches one instruction at a time
//
// Ports:
//   clk            core clock, all state updates on the rising edge
//   rst            synchronous active-high reset, overrides every other input
//   pc_next        next-PC from the next-PC logic, sampled only on retire
//   retire         current instruction completed (meaningful only in EXEC)
//   pc             current architectural PC
//   imem_req_valid fetch request valid (pure state decode, no input paths)
//   imem_req_ready memory accepts the request this cycle
//   imem_addr      fetch address, always equal to pc
//   imem_rsp_valid response data valid (accepted only while waiting)
//   imem_rsp_data  instruction word
//   instr          captured instruction
//   instr_valid    instr is valid and awaiting retire
//   misalign_trap  sticky, a misaligned pc_next was retired
//   retired_count  number of retired instructions, wraps modulo 2^32
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        retire,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign_trap,
    output logic [31:0] retired_count
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, TRAP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic        w_retire;
    logic        w_capture;

    assign w_retire  = (r_state == EXEC) && retire;
    assign w_capture = (r_state == WAIT) && imem_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = REQ;
            REQ:     w_next = imem_req_ready ? WAIT : REQ;
            WAIT:    w_next = imem_rsp_valid ? EXEC : WAIT;
            EXEC:    w_next = !retire ? EXEC : (pc_next[1:0] == 2'b00) ? REQ : TRAP;
            default: w_next = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_count <= 32'h0;
        end else begin
            if (w_capture) r_instr <= imem_rsp_data;
            if (w_retire) begin
                r_pc    <= pc_next;
                r_count <= r_count + 32'd1;
            end
        end
    end

    // All handshake outputs decode registered state only, keeping inputs
    // off the request path; TRAP is terminal so the trap flag is sticky.
    assign pc             = r_pc;
    assign imem_addr      = r_pc;
    assign imem_req_valid = (r_state == REQ);
    assign instr          = r_instr;
    assign instr_valid    = (r_state == EXEC);
    assign misalign_trap  = (r_state == TRAP);
    assign retired_count  = r_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized directed-sequence bench with a transaction-level PC model
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        retire;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign_trap;
    logic [31:0] retired_count;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .retire(retire), .pc(pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr(instr), .instr_valid(instr_valid),
        .misalign_trap(misalign_trap), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input int stall);
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 1'b0;
            check("req_stall_valid", {31'b0, imem_req_valid}, 1);
            check("req_stall_addr", imem_addr, m_pc);
            tick;
        end
        imem_req_ready = 1'b1;
        check("req_valid", {31'b0, imem_req_valid}, 1);
        check("req_addr", imem_addr, m_pc);
        tick;
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 0);
    endtask

    task automatic respond(input int lat, input logic [31:0] d);
        for (int i = 0; i < lat; i++) begin
            imem_rsp_valid = 1'b0;
            retire = 1'($urandom_range(1));
            pc_next = $urandom;
            tick;
            check("wait_ivalid", {31'b0, instr_valid}, 0);
            check("wait_pc", pc, m_pc);
            check("wait_count", retired_count, m_count);
        end
        retire = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = d;
        tick;
        imem_rsp_valid = 1'b0;
        m_instr = d;
        check("cap_ivalid", {31'b0, instr_valid}, 1);
        check("cap_instr", instr, m_instr);
    endtask

    task automatic execute(input int hold, input logic [31:0] nxt);
        logic ok;
        for (int i = 0; i < hold; i++) begin
            imem_rsp_valid = 1'($urandom_range(1));
            imem_rsp_data = $urandom;
            tick;
            check("exec_instr", instr, m_instr);
            check("exec_ivalid", {31'b0, instr_valid}, 1);
            check("exec_pc", pc, m_pc);
        end
        imem_rsp_valid = 1'b0;
        pc_next = nxt;
        retire = 1'b1;
        tick;
        retire = 1'b0;
        m_pc = nxt;
        m_count = m_count + 32'd1;
        ok = (nxt % 4) == 0;
        check("ret_pc", pc, m_pc);
        check("ret_count", retired_count, m_count);
        check("ret_ivalid", {31'b0, instr_valid}, 0);
        check("ret_trap", {31'b0, misalign_trap}, {31'b0, !ok});
        check("ret_req", {31'b0, imem_req_valid}, {31'b0, ok});
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_pc = RST_PC;
        m_count = 0;
        m_instr = 0;
        check("rst_pc", pc, m_pc);
        check("rst_instr", instr, 0);
        check("rst_ivalid", {31'b0, instr_valid}, 0);
        check("rst_req", {31'b0, imem_req_valid}, 0);
        check("rst_trap", {31'b0, misalign_trap}, 0);
        check("rst_count", retired_count, 0);
        tick;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        retire = 1'b0;
        pc_next = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 0;
        tick;
        apply_reset;
        issue(0);
        respond(0, 32'h0050_0093);
        execute(2, 32'h0000_0010);
        issue(3);
        respond(1, $urandom);
        execute(1, 32'h0000_0020);
        issue(0);
        respond(0, $urandom);
        for (int k = 0; k < 25; k++) begin
            r = $urandom;
            r = r & 32'hFFFF_FFFC;
            execute($urandom_range(3), r);
            issue($urandom_range(3));
            respond($urandom_range(3), $urandom);
        end
        force dut.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_count;
        m_count = 32'hFFFF_FFFF;
        execute(0, 32'h0000_0040);
        check("wrap_count", retired_count, 0);
        issue(0);
        respond(0, $urandom);
        execute(1, 32'h0000_0022);
        for (int i = 0; i < 20; i++) begin
            retire = 1'($urandom_range(1));
            imem_rsp_valid = 1'($urandom_range(1));
            imem_req_ready = 1'b1;
            pc_next = 0;
            tick;
            check("trap_req", {31'b0, imem_req_valid}, 0);
            check("trap_flag", {31'b0, misalign_trap}, 1);
            check("trap_pc", pc, 32'h0000_0022);
        end
        retire = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        apply_reset;
        issue(1);
        respond(0, $urandom);
        execute(0, 32'h0000_0100);
        issue(2);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        imem_rsp_valid = 1'b0;
        m_pc = RST_PC;
        m_count = 0;
        m_instr = 0;
        check("mid_rst_instr", instr, 0);
        check("mid_rst_ivalid", {31'b0, instr_valid}, 0);
        check("mid_rst_pc", pc, m_pc);
        check("mid_rst_count", retired_count, 0);
        check("mid_rst_req", {31'b0, imem_req_valid}, 0);
        tick;
        issue(0);
        respond(2, 32'h0000_0013);
        execute(1, 32'h0000_0004);
        check("final_count", retired_count, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
